seg_instruction_fetch: RTL and testbench

SEG_INSTRUCTION_FETCH -- requirements
Module: seg_instruction_fetch

---
 rtl/seg_instruction_fetch.sv | 132 +++++++++++++
 tb/tb_seg_instruction_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_instruction_fetch.sv
// rtl/seg_instruction_fetch.sv - IF stage: program memory, PC, IF/ID register, optional HALT detect (IF_HALT_DETECT_EN)
module seg_instruction_fetch #(
  parameter int LENGTH_INSTRUCTION = 32,
  parameter int NB_PC              = 32,
  parameter int NB_MEM_ADDR        = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_stall,
  input  logic                          i_flush,
  input  logic                          i_pc_src,
  input  logic [NB_PC-1:0]              i_branch_target,
  input  logic                          i_load_en,
  input  logic [NB_MEM_ADDR-1:0]        i_load_addr,
  input  logic [LENGTH_INSTRUCTION-1:0] i_load_data,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [NB_PC-1:0]              o_pc_plus4,
  output logic [NB_PC-1:0]              o_pc,
  output logic                          o_valid,
  output logic                          o_halt
);

  localparam int MEM_DEPTH = 1 << NB_MEM_ADDR;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [NB_PC-1:0]              pc_q, pc_d;
  logic [NB_PC-1:0]              pc_plus4_q, pc_plus4_d;
  logic [LENGTH_INSTRUCTION-1:0] instr_q, instr_d;
  logic                          valid_q, valid_d;

  logic [LENGTH_INSTRUCTION-1:0] mem_q [MEM_DEPTH];
  logic [LENGTH_INSTRUCTION-1:0] fetch_word;
  logic [NB_PC-1:0]              pc_next_seq;
  logic [NB_PC-1:0]              redirect_pc;
  logic                          is_halt_op;

  // Word-addressed read; upper PC bits beyond the memory size simply wrap.
  assign fetch_word  = mem_q[pc_q[NB_MEM_ADDR+1:2]];
  assign pc_next_seq = pc_q + NB_PC'(4);
  // Redirect targets are forced word-aligned.
  assign redirect_pc = i_branch_target & ~NB_PC'(3);

`ifdef IF_HALT_DETECT_EN
  assign is_halt_op = (fetch_word[LENGTH_INSTRUCTION-1 -: 6] == 6'b111111);
  assign o_halt     = (state_q == ST_HALTED);
`else
  assign is_halt_op = 1'b0;
  assign o_halt     = 1'b0;
`endif

  // State, PC and IF/ID registers; program memory is deliberately outside reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  // Program load port, only honoured while the fetch engine is idle.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_IDLE && i_load_en) begin
      mem_q[i_load_addr] <= i_load_data;
    end
  end

  // Next-state and datapath: redirect beats stall for PC, flush beats stall for IF/ID.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          if (i_pc_src)      pc_d = redirect_pc;
          else if (!i_stall) pc_d = pc_next_seq;

          if (i_flush) begin
            instr_d    = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
          end else if (!i_stall) begin
            instr_d    = fetch_word;
            pc_plus4_d = pc_next_seq;
            valid_d    = 1'b1;
            if (is_halt_op) state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (i_flush) begin
          instr_d    = '0;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
          if (i_pc_src) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_pc          = pc_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// tb/tb_seg_instruction_fetch.sv - directed self-checking bench for seg_instruction_fetch
module tb_seg_instruction_fetch;

  logic        i_clk;
  logic        i_rst;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic        i_pc_src;
  logic [31:0] i_branch_target;
  logic        i_load_en;
  logic [7:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_halt;

  int n_pass;
  int n_total;

  seg_instruction_fetch #(
    .LENGTH_INSTRUCTION(32),
    .NB_PC(32),
    .NB_MEM_ADDR(8)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_enable(i_enable),
    .i_stall(i_stall),
    .i_flush(i_flush),
    .i_pc_src(i_pc_src),
    .i_branch_target(i_branch_target),
    .i_load_en(i_load_en),
    .i_load_addr(i_load_addr),
    .i_load_data(i_load_data),
    .o_instruction(o_instruction),
    .o_pc_plus4(o_pc_plus4),
    .o_pc(o_pc),
    .o_valid(o_valid),
    .o_halt(o_halt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // one rising edge, then settle on the falling edge for sampling/driving
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    i_load_en   = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    step();
    i_load_en   = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld, input logic [31:0] pc);
    check({tag, ".instr"}, o_instruction, instr);
    check({tag, ".pc4"},   o_pc_plus4,    pc4);
    check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, vld});
    check({tag, ".pc"},    o_pc,          pc);
  endtask

  task automatic check_zero(input string tag);
    check_ifid(tag, 32'h0, 32'h0, 1'b0, 32'h0);
    check({tag, ".halt"}, {31'd0, o_halt}, 32'h0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    i_rst = 1'b0;
    i_enable = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_pc_src = 1'b0;
    i_branch_target = 32'h0;
    i_load_en = 1'b0;
    i_load_addr = 8'h0;
    i_load_data = 32'h0;
    #1;
    check_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b1;

    // program load while idle
    load(8'd0,   32'h20010005);
    load(8'd1,   32'h20020007);
    load(8'd2,   32'h20030009);
    load(8'd3,   32'h2003000D);
    load(8'd4,   32'h2004000B);
    load(8'd5,   32'h2005000D);
    load(8'd16,  32'hAAAA0010);
    load(8'd255, 32'hBEEF00FF);
    check_zero("idle_after_load");

    // basic fetch: one cycle to enter RUN, then back-to-back words
    i_enable = 1'b1;
    step();
    check("enter_run.pc", o_pc, 32'h0);
    step();
    check_ifid("fetch0", 32'h20010005, 32'd4, 1'b1, 32'd4);
    step();
    check_ifid("fetch1", 32'h20020007, 32'd8, 1'b1, 32'd8);

    // stall three cycles at PC=8; a load attempt during RUN must be ignored
    i_stall = 1'b1;
    i_load_en = 1'b1; i_load_addr = 8'd0; i_load_data = 32'hDEADDEAD;
    for (int k = 0; k < 3; k++) begin
      step();
      check_ifid("stall", 32'h20020007, 32'd8, 1'b1, 32'd8);
    end
    i_stall = 1'b0;
    i_load_en = 1'b0;
    step();
    check_ifid("resume", 32'h20030009, 32'd12, 1'b1, 32'd12);
    step();
    check_ifid("fetch3", 32'h2003000D, 32'd16, 1'b1, 32'd16);

    // redirect + flush at PC=16 with unaligned target
    i_pc_src = 1'b1; i_flush = 1'b1; i_branch_target = 32'h43;
    step();
    check_ifid("flush", 32'h0, 32'h0, 1'b0, 32'h40);
    i_pc_src = 1'b0; i_flush = 1'b0;
    step();
    check_ifid("after_flush", 32'hAAAA0010, 32'h44, 1'b1, 32'h44);

    // redirect wins over stall; IF/ID holds
    i_pc_src = 1'b1; i_stall = 1'b1; i_branch_target = 32'h100;
    step();
    check_ifid("redir_stall", 32'hAAAA0010, 32'h44, 1'b1, 32'h100);

    // memory index wraps past the last word
    i_stall = 1'b0; i_branch_target = 32'h3FC;
    step();
    check("wrap_redir.pc", o_pc, 32'h3FC);
    i_pc_src = 1'b0;
    step();
    check_ifid("last_word", 32'hBEEF00FF, 32'h400, 1'b1, 32'h400);
    step();
    check_ifid("wrapped", 32'h20010005, 32'h404, 1'b1, 32'h404);

    // asynchronous reset mid-run at PC=0x3FC
    i_pc_src = 1'b1; i_branch_target = 32'h3FC;
    step();
    i_pc_src = 1'b0;
    check("pre_reset.pc", o_pc, 32'h3FC);
    #2 i_rst = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    step();
    check("rerun_enter.pc", o_pc, 32'h0);
    step();
    check_ifid("refetch0", 32'h20010005, 32'd4, 1'b1, 32'd4);

    // drop enable: back to IDLE, state held
    i_enable = 1'b0;
    step();
    check_ifid("to_idle", 32'h20010005, 32'd4, 1'b1, 32'd4);

    // HALT opcode at word 3
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    load(8'd3, 32'hFC000000);
    i_enable = 1'b1;
    step();
    step();
    step();
    step();
    check_ifid("pre_halt", 32'h20030009, 32'd12, 1'b1, 32'd12);
    step();
    check_ifid("halt_cap", 32'hFC000000, 32'd16, 1'b1, 32'd16);
`ifdef IF_HALT_DETECT_EN
    check("halt_cap.halt", {31'd0, o_halt}, 32'd1);
    step();
    check_ifid("halted1", 32'hFC000000, 32'd16, 1'b1, 32'd16);
    check("halted1.halt", {31'd0, o_halt}, 32'd1);
    i_flush = 1'b1;
    step();
    check_ifid("halted_flush", 32'h0, 32'h0, 1'b0, 32'd16);
    check("halted_flush.halt", {31'd0, o_halt}, 32'd1);
    i_pc_src = 1'b1; i_branch_target = 32'h40;
    step();
    check_ifid("unhalt", 32'h0, 32'h0, 1'b0, 32'h40);
    check("unhalt.halt", {31'd0, o_halt}, 32'd0);
    i_flush = 1'b0; i_pc_src = 1'b0;
    step();
    check_ifid("post_unhalt", 32'hAAAA0010, 32'h44, 1'b1, 32'h44);
`else
    check("halt_cap.halt", {31'd0, o_halt}, 32'd0);
    step();
    check_ifid("no_halt1", 32'h2004000B, 32'd20, 1'b1, 32'd20);
    check("no_halt1.halt", {31'd0, o_halt}, 32'd0);
    step();
    check_ifid("no_halt2", 32'h2005000D, 32'd24, 1'b1, 32'd24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
